// File: rtl/if_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response channel plus the
// decode-side presentation channel.
//   master : the fetch queue (drives requests and the decode-facing pair)
//   slave  : the environment (memory model / decode stage)
// Signals:
//   imem_req_valid/ready/addr : fetch request handshake
//   imem_rsp_valid/data       : in-order responses, no backpressure
//   id_valid/ready/pc/instr   : head entry presented to decode
interface if_fetch_queue_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_instr;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output id_valid,
    input  id_ready,
    output id_pc,
    output id_instr
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  id_valid,
    output id_ready,
    input  id_pc,
    input  id_instr
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue sitting behind the PC counter.
// Issues the current PC to instruction memory, collects in-order responses into a
// DEPTH-entry queue of {pc, instr} pairs and presents the head to decode. A flush
// (branch redirect) discards every queued entry and turns all outstanding
// responses into drops.
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   pc           : current PC from the PC counter
//   flush        : branch redirect (PC counter loads the target)
//   pc_write     : PC counter update enable (request accepted or flush)
//   bus          : memory request/response and decode channels (master side)
module if_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [XLEN-1:0]  pc,
  input  logic             flush,
  output logic             pc_write,
  if_fetch_queue_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [PtrW-1:0]  fill_q, fill_d;
  logic [CntW-1:0]  alloc_q, alloc_d;
  logic [CntW-1:0]  inflight_q, inflight_d;
  logic [CntW-1:0]  drop_q, drop_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [XLEN-1:0]  pc_mem_q [DEPTH];
  logic [XLEN-1:0]  instr_mem_q [DEPTH];
  // Holds requests off for the first cycle after reset release so nothing is
  // issued while reset_n is low.
  logic             active_q;

  logic full;
  logic req_valid;
  logic accept;
  logic rsp_keep;
  logic head_valid;
  logic pop;

  // Request / pop qualification
  always_comb begin
    full       = (alloc_q == DepthCnt);
    // While drops are pending, issue only when a response retires one this
    // cycle, so drops plus allocated entries never exceed DEPTH in flight.
    req_valid  = active_q && !flush && !full &&
                 ((drop_q == '0) || bus.imem_rsp_valid);
    accept     = req_valid && bus.imem_req_ready;
    rsp_keep   = bus.imem_rsp_valid && (drop_q == '0) && !flush;
    head_valid = (alloc_q != '0) && filled_q[head_q];
    pop        = head_valid && bus.id_ready && !flush;
  end

  // Next-state
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    alloc_d    = alloc_q;
    filled_d   = filled_q;
    inflight_d = inflight_q + CntW'(accept) - CntW'(bus.imem_rsp_valid);
    drop_d     = drop_q;

    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      alloc_d  = '0;
      filled_d = '0;
      // Everything still outstanding after this cycle's response is wrong-path.
      drop_d   = inflight_q - CntW'(bus.imem_rsp_valid);
    end else begin
      if (pop) begin
        head_d           = head_q + PtrW'(1);
        filled_d[head_q] = 1'b0;
      end
      if (accept) begin
        tail_d           = tail_q + PtrW'(1);
        filled_d[tail_q] = 1'b0;
      end
      if (rsp_keep) begin
        fill_d           = fill_q + PtrW'(1);
        filled_d[fill_q] = 1'b1;
      end
      alloc_d = alloc_q + CntW'(accept) - CntW'(pop);
      if (bus.imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CntW'(1);
      end
    end
  end

  // Control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      alloc_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
      active_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      alloc_q    <= alloc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      filled_q   <= filled_d;
      active_q   <= 1'b1;
    end
  end

  // Entry storage; cleared on reset so id_pc/id_instr read zero afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        pc_mem_q[tail_q] <= pc;
      end
      if (rsp_keep) begin
        instr_mem_q[fill_q] <= bus.imem_rsp_data;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = pc;
    bus.id_valid       = head_valid;
    bus.id_pc          = pc_mem_q[head_q];
    bus.id_instr       = instr_mem_q[head_q];
    pc_write           = accept || (active_q && flush);
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 32;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    bit          wrong;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    bit          filled;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        flush;
  logic        pc_write;

  if_fetch_queue_if #(.XLEN(XLEN)) bus_if ();

  if_fetch_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pc       (pc),
    .flush    (flush),
    .pc_write (pc_write),
    .bus      (bus_if.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  int unsigned cyc      = 0;
  int unsigned since_rst = 0;
  int unsigned acc_cnt  = 0;
  int unsigned lat_min  = 1;
  int unsigned lat_max  = 1;

  mreq_t       mem_q[$];
  ent_t        mdl_q[$];
  logic [31:0] got_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0] ^ 16'h0013};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Entered at posedge+1; asserts reset mid-cycle and releases it at posedge+1.
  task automatic apply_reset(input logic [31:0] start_pc);
    #3 reset_n = 1'b0;
    #1;
    check_eq("rst_id_valid", 32'(bus_if.id_valid), 32'd0);
    check_eq("rst_req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    check_eq("rst_pc_write", 32'(pc_write), 32'd0);
    check_eq("rst_id_pc", bus_if.id_pc, 32'd0);
    check_eq("rst_id_instr", bus_if.id_instr, 32'd0);
    mem_q.delete();
    mdl_q.delete();
    got_q.delete();
    pc = start_pc;
    flush = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    since_rst = 0;
    acc_cnt = 0;
  endtask

  // One clock cycle: drive, check at negedge, update reference, advance PC.
  task automatic step(input bit fl, input logic [31:0] tgt);
    bit rsp, acc, exp_valid, pop;
    int nwrong;
    int unsigned due;
    flush = fl;
    rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
    bus_if.imem_rsp_valid = rsp;
    bus_if.imem_rsp_data = rsp ? mem_word(mem_q[0].addr) : 32'd0;
    @(negedge clk);
    acc = bus_if.imem_req_valid && bus_if.imem_req_ready;
    exp_valid = (mdl_q.size() != 0) && mdl_q[0].filled;
    check_eq("id_valid", 32'(bus_if.id_valid), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("id_pc", bus_if.id_pc, mdl_q[0].pc);
      check_eq("id_instr", bus_if.id_instr, mem_word(mdl_q[0].pc));
    end
    check_eq("pc_write", 32'(pc_write), 32'(acc || fl));
    if (bus_if.imem_req_valid) check_eq("req_addr", bus_if.imem_req_addr, pc);
    nwrong = 0;
    foreach (mem_q[i]) if (mem_q[i].wrong) nwrong++;
    if (fl || mdl_q.size() >= DEPTH || since_rst == 0) begin
      check_eq("req_gated", 32'(bus_if.imem_req_valid), 32'd0);
    end else if (nwrong == 0) begin
      check_eq("req_issue", 32'(bus_if.imem_req_valid), 32'd1);
    end
    pop = exp_valid && bus_if.id_ready && !fl;
    if (fl) begin
      foreach (mem_q[i]) mem_q[i].wrong = 1'b1;
      mdl_q.delete();
    end
    if (rsp) begin
      if (!mem_q[0].wrong) begin
        for (int i = 0; i < mdl_q.size(); i++) begin
          if (!mdl_q[i].filled) begin
            mdl_q[i].filled = 1'b1;
            break;
          end
        end
      end
      void'(mem_q.pop_front());
    end
    if (pop) begin
      got_q.push_back(mdl_q[0].pc);
      void'(mdl_q.pop_front());
    end
    if (acc) begin
      mdl_q.push_back('{pc: pc, filled: 1'b0});
      due = cyc + $urandom_range(lat_max, lat_min);
      if (mem_q.size() != 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
      mem_q.push_back('{addr: pc, due: due, wrong: 1'b0});
      acc_cnt++;
    end
    @(posedge clk);
    #1;
    if (fl) pc = tgt;
    else if (acc) pc = pc + 32'd4;
    cyc++;
    since_rst++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0);
  endtask

  initial begin
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    reset_n = 1'b0;
    pc = '0;
    flush = 1'b0;
    bus_if.imem_req_ready = 1'b1;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data = '0;
    bus_if.id_ready = 1'b1;
    @(posedge clk);
    #1;

    // Streaming, latency 1
    apply_reset(32'h0);
    lat_min = 1; lat_max = 1;
    run(12);
    check_eq("a_npop", 32'(got_q.size() >= 3), 32'd1);
    if (got_q.size() >= 3) begin
      check_eq("a_pc0", got_q[0], 32'h0);
      check_eq("a_pc1", got_q[1], 32'h4);
      check_eq("a_pc2", got_q[2], 32'h8);
    end

    // Decode stalled: queue fills, then one pop frees one slot
    apply_reset(32'h1000);
    bus_if.id_ready = 1'b0;
    run(10);
    check_eq("b_acc_full", acc_cnt, 32'd4);
    check_eq("b_head_hold", bus_if.id_pc, 32'h1000);
    bus_if.id_ready = 1'b1;
    run(1);
    bus_if.id_ready = 1'b0;
    run(3);
    check_eq("b_acc_after_pop", acc_cnt, 32'd5);
    bus_if.id_ready = 1'b1;

    // Flush with three requests in flight
    apply_reset(32'h10);
    lat_min = 4; lat_max = 4;
    run(4);
    check_eq("c_inflight", 32'(mem_q.size()), 32'd3);
    step(1'b1, 32'h100);
    run(20);
    check_eq("c_npop", 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0) check_eq("c_first_pc", got_q[0], 32'h100);

    // Response arriving in the flush cycle, one other outstanding
    apply_reset(32'h40);
    lat_min = 2; lat_max = 2;
    run(3);
    step(1'b1, 32'h200);
    run(12);
    if (got_q.size() != 0) check_eq("d_first_pc", got_q[0], 32'h200);
    else check_eq("d_npop", 32'd0, 32'd1);

    // Request-ready toggling 1,0,0,1
    apply_reset(32'h2000);
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 16; i++) begin
      bus_if.imem_req_ready = pat[i % 4];
      step(1'b0, 32'd0);
    end
    bus_if.imem_req_ready = 1'b1;
    run(6);
    check_eq("e_first_pc", (got_q.size() != 0) ? got_q[0] : 32'hFFFF_FFFF, 32'h2000);
    for (int i = 1; i < got_q.size(); i++) check_eq("e_seq", got_q[i], got_q[i-1] + 32'd4);

    // Randomized traffic with flushes
    apply_reset(32'h3000);
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1200; i++) begin
      bus_if.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus_if.id_ready = ($urandom_range(3, 0) != 0);
      step($urandom_range(29, 0) == 0, {18'd0, 12'($urandom_range(4095, 0)), 2'b00});
    end

    // Asynchronous reset in the middle of traffic, then restart
    apply_reset(32'h5000);
    bus_if.imem_req_ready = 1'b1;
    bus_if.id_ready = 1'b1;
    run(30);
    check_eq("f_first_pc", (got_q.size() != 0) ? got_q[0] : 32'hFFFF_FFFF, 32'h5000);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
